// File: rtl/frogger_vga_if.sv
// Pixel/colour handshake between the Frogger renderer and the VGA timing block.
// The VGA block is the master: it drives the raster position and sync/colour outputs and reads the palette index.
interface frogger_vga_if;
  logic [0:5] colorcode;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic [7:0] VGA_R;
  logic [7:0] VGA_G;
  logic [7:0] VGA_B;
  logic       frame_start;

  modport master (
    input  colorcode,
    output DrawX, DrawY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
    output VGA_R, VGA_G, VGA_B, frame_start
  );

  modport slave (
    output colorcode,
    input  DrawX, DrawY, VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N,
    input  VGA_R, VGA_G, VGA_B, frame_start
  );
endinterface

// File: rtl/frogger_vga_out.sv
// 640x480@60 VGA raster generator with the Frogger 15-entry palette.
// It runs on the 50 MHz clock and uses a divide-by-two pixel enable; all outputs are registered with one pixel of latency.
module frogger_vga_out #(
  parameter int V_VISIBLE    = 480,
  parameter int V_SYNC_START = 490,
  parameter int V_SYNC_END   = 491,
  parameter int V_TOTAL      = 525
) (
  input  logic          Clk,
  input  logic          Reset,
  frogger_vga_if.master vga
);

  localparam logic [9:0] H_VIS = 10'd640;
  localparam logic [9:0] H_SS  = 10'd656;
  localparam logic [9:0] H_SE  = 10'd751;
  localparam logic [9:0] H_MAX = 10'd799;
  localparam logic [9:0] V_VIS = 10'(V_VISIBLE);
  localparam logic [9:0] V_SS  = 10'(V_SYNC_START);
  localparam logic [9:0] V_SE  = 10'(V_SYNC_END);
  localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

  logic        pix_en_q;
  logic [9:0]  hcount_q, hcount_d;
  logic [9:0]  vcount_q, vcount_d;
  logic        hs_q, hs_d;
  logic        vs_q, vs_d;
  logic        blank_n_q, blank_n_d;
  logic        fs_q, fs_d;
  logic [23:0] rgb_q, rgb_d;
  logic        visible;

  function automatic logic [23:0] palette(input logic [5:0] idx);
    case (idx)
      6'd0:    palette = 24'hFFFFFF;
      6'd1:    palette = 24'h000000;
      6'd2:    palette = 24'h27B212;
      6'd3:    palette = 24'hD80222;
      6'd4:    palette = 24'h5DB1F0;
      6'd5:    palette = 24'hF1FF0A;
      6'd6:    palette = 24'hB2B2B0;
      6'd7:    palette = 24'hF27A00;
      6'd8:    palette = 24'h663300;
      6'd9:    palette = 24'h8600B3;
      6'd10:   palette = 24'h000066;
      6'd11:   palette = 24'hFFFFFF;
      6'd12:   palette = 24'h70F248;
      6'd13:   palette = 24'h404040;
      6'd14:   palette = 24'hFFA64D;
      default: palette = 24'h000000;
    endcase
  endfunction

  always_comb begin
    visible   = (hcount_q < H_VIS) && (vcount_q < V_VIS);
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    blank_n_d = blank_n_q;
    rgb_d     = rgb_q;
    fs_d      = 1'b0;
    if (pix_en_q) begin
      // >= rather than == so a corrupted counter still recovers to 0
      hcount_d = (hcount_q >= H_MAX) ? 10'd0 : hcount_q + 10'd1;
      if (hcount_q >= H_MAX)
        vcount_d = (vcount_q >= V_MAX) ? 10'd0 : vcount_q + 10'd1;
      hs_d      = !((hcount_q >= H_SS) && (hcount_q <= H_SE));
      vs_d      = !((vcount_q >= V_SS) && (vcount_q <= V_SE));
      blank_n_d = visible;
      rgb_d     = visible ? palette(vga.colorcode) : 24'h000000;
      fs_d      = (hcount_q == H_MAX) && (vcount_q == V_VIS - 10'd1);
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pix_en_q  <= 1'b0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      rgb_q     <= '0;
      fs_q      <= 1'b0;
    end else begin
      pix_en_q  <= !pix_en_q;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      rgb_q     <= rgb_d;
      fs_q      <= fs_d;
    end
  end

  assign vga.DrawX       = hcount_q;
  assign vga.DrawY       = vcount_q;
  assign vga.VGA_CLK     = pix_en_q;
  assign vga.VGA_HS      = hs_q;
  assign vga.VGA_VS      = vs_q;
  assign vga.VGA_BLANK_N = blank_n_q;
  assign vga.VGA_R       = rgb_q[23:16];
  assign vga.VGA_G       = rgb_q[15:8];
  assign vga.VGA_B       = rgb_q[7:0];
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_frogger_vga_out.sv
// Bench for frogger_vga_out: a full-size instance for horizontal timing and palette, and a
// short-frame instance (9 lines) so vertical timing, frame_start and frame wrap fit in a short run.
module tb_frogger_vga_out;
  logic Clk;
  logic Reset;
  int   checks   = 0;
  int   failures = 0;

  frogger_vga_if if0();
  frogger_vga_if if1();

  frogger_vga_out u_dut (.Clk(Clk), .Reset(Reset), .vga(if0.master));
  frogger_vga_out #(.V_VISIBLE(4), .V_SYNC_START(6), .V_SYNC_END(7), .V_TOTAL(9))
    u_small (.Clk(Clk), .Reset(Reset), .vga(if1.master));

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [23:0] pal [64];
  initial begin
    for (int i = 0; i < 64; i++) pal[i] = 24'h000000;
    pal[0]  = 24'hFFFFFF; pal[1]  = 24'h000000; pal[2]  = 24'h27B212; pal[3]  = 24'hD80222;
    pal[4]  = 24'h5DB1F0; pal[5]  = 24'hF1FF0A; pal[6]  = 24'hB2B2B0; pal[7]  = 24'hF27A00;
    pal[8]  = 24'h663300; pal[9]  = 24'h8600B3; pal[10] = 24'h000066; pal[11] = 24'hFFFFFF;
    pal[12] = 24'h70F248; pal[13] = 24'h404040; pal[14] = 24'hFFA64D;
  end

  function automatic logic [48:0] word(input logic [9:0] x, input logic [9:0] y, input logic ck,
                                       input logic hs, input logic vs, input logic bl,
                                       input logic fs, input logic [23:0] rgb);
    word = {x, y, ck, hs, vs, bl, fs, rgb};
  endfunction

  logic [48:0] w0, w1;
  assign w0 = word(if0.DrawX, if0.DrawY, if0.VGA_CLK, if0.VGA_HS, if0.VGA_VS, if0.VGA_BLANK_N,
                   if0.frame_start, {if0.VGA_R, if0.VGA_G, if0.VGA_B});
  assign w1 = word(if1.DrawX, if1.DrawY, if1.VGA_CLK, if1.VGA_HS, if1.VGA_VS, if1.VGA_BLANK_N,
                   if1.frame_start, {if1.VGA_R, if1.VGA_G, if1.VGA_B});
  localparam logic [48:0] RST_WORD = {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 24'h0};

  // Reference raster for the short-frame instance (white colorcode throughout)
  logic        m_pe, e_hs, e_vs, e_bl, e_fs;
  logic [9:0]  m_h, m_v;
  logic [23:0] e_rgb;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_pe <= 1'b0; m_h <= '0; m_v <= '0;
      e_hs <= 1'b1; e_vs <= 1'b1; e_bl <= 1'b0; e_fs <= 1'b0; e_rgb <= '0;
    end else begin
      m_pe <= !m_pe;
      e_fs <= 1'b0;
      if (m_pe) begin
        m_h   <= (m_h == 10'd799) ? 10'd0 : m_h + 10'd1;
        if (m_h == 10'd799) m_v <= (m_v == 10'd8) ? 10'd0 : m_v + 10'd1;
        e_hs  <= !(m_h >= 10'd656 && m_h <= 10'd751);
        e_vs  <= !(m_v >= 10'd6 && m_v <= 10'd7);
        e_bl  <= (m_h < 10'd640 && m_v < 10'd4);
        e_rgb <= (m_h < 10'd640 && m_v < 10'd4) ? 24'hFFFFFF : 24'h0;
        e_fs  <= (m_h == 10'd799 && m_v == 10'd3);
      end
    end
  end

  always @(negedge Clk)
    if (!Reset) chk("sb_small", w1, word(m_h, m_v, m_pe, e_hs, e_vs, e_bl, e_fs, e_rgb));

  // Edge timestamps for sync period/width measurements
  int   cyc = 0;
  logic prev_hs0 = 1'b1, prev_vs1 = 1'b1;
  int   hs_fall_prev = 0, hs_fall_last = 0, hs_rise_last = 0;
  int   vs_fall_prev = 0, vs_fall_last = 0, vs_rise_last = 0;
  int   fs_cnt = 0, fs_per_frame = 0;
  logic [9:0] mx1 = '0, my1 = '0;
  always @(negedge Clk) begin
    cyc      <= cyc + 1;
    prev_hs0 <= if0.VGA_HS;
    prev_vs1 <= if1.VGA_VS;
    if (prev_hs0 && !if0.VGA_HS) begin hs_fall_prev <= hs_fall_last; hs_fall_last <= cyc; end
    if (!prev_hs0 && if0.VGA_HS) hs_rise_last <= cyc;
    if (prev_vs1 && !if1.VGA_VS) begin
      vs_fall_prev <= vs_fall_last; vs_fall_last <= cyc;
      fs_per_frame <= fs_cnt; fs_cnt <= 0;
    end else if (if1.frame_start) fs_cnt <= fs_cnt + 1;
    if (!prev_vs1 && if1.VGA_VS) vs_rise_last <= cyc;
    if (if1.DrawX > mx1) mx1 <= if1.DrawX;
    if (if1.DrawY > my1) my1 <= if1.DrawY;
  end

  task automatic wait_px(input bit sel, input int x, input int y);
    bit ok = 1'b0;
    for (int n = 0; n < 50000; n++) begin
      @(negedge Clk);
      if (sel ? (if1.DrawX == x && if1.DrawY == y && if1.VGA_CLK)
              : (if0.DrawX == x && if0.DrawY == y && if0.VGA_CLK)) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("wait_%0d_%0d_%0d", sel, x, y), {63'd0, ok}, 64'd1);
  endtask

  initial begin
    Reset = 1'b1;
    if0.colorcode = 6'd0;
    if1.colorcode = 6'd0;
    repeat (3) @(negedge Clk);
    chk("rst_hold_main", w0, RST_WORD);
    chk("rst_hold_small", w1, RST_WORD);

    Reset = 1'b0;
    @(negedge Clk);
    chk("rel_edge1", {if0.DrawX, if0.VGA_CLK}, {10'd0, 1'b1});
    @(negedge Clk);
    chk("rel_edge2", {if0.DrawX, if0.VGA_CLK}, {10'd1, 1'b0});

    // Right edge of the visible region with white colorcode, then HS window edges
    wait_px(1'b0, 639, 0); @(negedge Clk);
    chk("px639_white", {if0.VGA_BLANK_N, if0.VGA_R, if0.VGA_G, if0.VGA_B}, {1'b1, 24'hFFFFFF});
    wait_px(1'b0, 640, 0); @(negedge Clk);
    chk("px640_blank", {if0.VGA_BLANK_N, if0.VGA_R, if0.VGA_G, if0.VGA_B}, {1'b0, 24'h0});
    wait_px(1'b0, 655, 0); @(negedge Clk); chk("hs_655", if0.VGA_HS, 1'b1);
    wait_px(1'b0, 656, 0); @(negedge Clk); chk("hs_656", if0.VGA_HS, 1'b0);
    wait_px(1'b0, 751, 0); @(negedge Clk); chk("hs_751", if0.VGA_HS, 1'b0);
    wait_px(1'b0, 752, 0); @(negedge Clk); chk("hs_752", if0.VGA_HS, 1'b1);

    // Whole palette at (10+i, 20)
    for (int i = 0; i < 64; i++) begin
      wait_px(1'b0, 10 + i, 20);
      if0.colorcode = 6'(i);
      @(negedge Clk);
      chk($sformatf("pal_%0d", i), {if0.VGA_BLANK_N, if0.VGA_R, if0.VGA_G, if0.VGA_B}, {1'b1, pal[i]});
    end
    if0.colorcode = 6'd0;

    chk("hs_period", hs_fall_last - hs_fall_prev, 1600);
    chk("hs_low", hs_rise_last - hs_fall_last, 192);
    chk("vs_period", vs_fall_last - vs_fall_prev, 9 * 1600);
    chk("vs_low", vs_rise_last - vs_fall_last, 2 * 1600);
    chk("fs_per_frame", fs_per_frame, 1);

    // Asynchronous reset mid-line, then restart from (0,0)
    wait_px(1'b1, 300, 2);
    #3 Reset = 1'b1;
    #1;
    chk("rst_async_main", w0, RST_WORD);
    chk("rst_async_small", w1, RST_WORD);
    repeat (3) @(negedge Clk);
    chk("rst_held_small", w1, RST_WORD);
    Reset = 1'b0;

    wait_px(1'b1, 799, 3); @(negedge Clk);
    chk("fs_rise", {if1.DrawX, if1.DrawY, if1.frame_start}, {10'd0, 10'd4, 1'b1});
    @(negedge Clk);
    chk("fs_fall", if1.frame_start, 1'b0);
    wait_px(1'b1, 799, 8); @(negedge Clk);
    chk("frame_wrap", {if1.DrawX, if1.DrawY}, {10'd0, 10'd0});
    chk("max_x", mx1, 10'd799);
    chk("max_y", my1, 10'd8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frogger_vga_out.md
FROGGER_VGA_OUT -- requirements
Module: frogger_vga_out

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-002 Clk  input  1  system clock, 50 MHz; all state updates on its rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset of all state.
REQ-004 colorcode  input  6 ([0:5], bit 0 = MSB)  palette index for the current DrawX/DrawY, supplied combinationally by the game renderer.
REQ-005 DrawX  output  10  current pixel column, equal to the internal horizontal counter.
REQ-006 DrawY  output  10  current pixel row, equal to the internal vertical counter.
REQ-007 VGA_CLK  output  1  25 MHz pixel clock, equal to the internal pixel-enable toggle register.
REQ-008 VGA_HS, VGA_VS  output  1 each  horizontal and vertical sync, active-low, registered.
REQ-009 VGA_BLANK_N  output  1  high while the registered pixel is visible.
REQ-010 VGA_R, VGA_G, VGA_B  output  8 each  registered pixel colour.
REQ-011 frame_start  output  1  one-Clk pulse marking the start of vertical blanking, used to step game state.

Function
REQ-012 The pix_en register SHALL toggle every Clk; counters and output registers advance only on Clk edges where pix_en = 1.
REQ-013 hcount SHALL count 0..799 and wrap to 0; vcount SHALL increment when hcount wraps, counting 0..524 and wrapping to 0.
REQ-014 Visible region SHALL be hcount < 640 and vcount < 480.
REQ-015 The HS-low window SHALL be hcount 656..751 inclusive.
REQ-016 The VS-low window SHALL be vcount 490..491 inclusive.
REQ-017 On every pix_en edge, VGA_HS, VGA_VS, VGA_BLANK_N and RGB SHALL all register values derived from the same hcount/vcount/colorcode, giving a uniform 1-pixel latency.
REQ-018 Palette, with index = unsigned colorcode, SHALL be: 0 FFFFFF; 1 000000; 2 27B212; 3 D80222; 4 5DB1F0; 5 F1FF0A; 6 B2B2B0; 7 F27A00; 8 663300; 9 8600B3; 10 000066; 11 FFFFFF; 12 70F248; 13 404040; 14 FFA64D.
REQ-019 Indices 15..63 SHALL map to 000000.
REQ-020 Outside the visible region, RGB SHALL register 000000 regardless of colorcode.
REQ-021 frame_start SHALL pulse high for exactly one Clk on the pix_en edge where the counters move from (799,479) to (0,480), and SHALL be low on all other cycles.
REQ-022 At (799,524) both counters SHALL wrap to (0,0) on the same edge.
REQ-023 No counter SHALL ever exceed 799 or 524.

Reset
REQ-024 While Reset = 1, and immediately on its assertion even mid-line or mid-frame, the block SHALL hold: pix_en = 0, hcount = 0, vcount = 0, VGA_HS = 1, VGA_VS = 1, VGA_BLANK_N = 0, RGB = 0, frame_start = 0.
REQ-025 After Reset deasserts, the first Clk edge SHALL set pix_en = 1 and the second Clk edge SHALL advance hcount to 1.

Verification
REQ-026 Scenario: release reset and count Clk edges between successive VGA_HS falling edges -> 1600 Clk; HS low width 192 Clk.
REQ-027 Scenario: count VS period and low width -> 525 lines (840000 Clk); VS low for 2 lines; frame_start pulses exactly once per frame, 1 Clk wide, at the (0,480) transition.
REQ-028 Scenario: drive colorcode = 6'b000010 with counters at (10,20) -> RGB = 27B212 and BLANK_N = 1 one pixel later; colorcode = 6'b001010 -> 000066; colorcode = 6'b111111 -> 000000.
REQ-029 Scenario: drive colorcode = 0 (white) across the whole frame -> RGB = 000000 and BLANK_N = 0 for the registered pixels at hcount 640..799 and vcount 480..524.
REQ-030 Scenario: assert Reset at (300,200) mid-frame -> all outputs take their REQ-024 values asynchronously; after release, the next frame begins at (0,0) with correct HS/VS timing.
REQ-031 Scenario: observe the frame wrap (799,524) -> (0,0) -> both counters wrap on the same pix_en edge; DrawX and DrawY never exceed 799 or 524.
